timer_dev: RTL and testbench
============================

Name: timer_dev

Overview:
- Memory-mapped countdown timer that responds to the pipeline's data-side load/store accesses.
- It is the responder end of the M-stage data bus. The bus bridge decodes the address window and drives `sel`, the word offset and write data; the block returns read data combinationally.
- It counts down from a programmed preset and raises an interrupt request toward the CPU.
- Provides one-shot and auto-reload modes with a maskable interrupt.

Parameters:
- PRESET_RST, 32'd0: reset value of the PRESET register.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sel  input  1  device selected by the bridge this cycle.
- we  input  1  store strobe; only effective when sel=1.
- addr  input  2  word offset (byte address [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- wdata  input  32  store data (word only).
- rdata  output  32  read data for addr; combinational.
- irq  output  1  interrupt request to the CPU.

Behaviour:
- Registers:
  - CTRL[3:0]: bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (interrupt mask enable).
  - PRESET[31:0].
  - COUNT[31:0], read-only.
  - Internal irq_flag.
- Reset: CTRL=0, PRESET=PRESET_RST, COUNT=0, irq_flag=0, state=IDLE, irq=0.
- rdata:
  - addr0 returns {28'b0,CTRL}; addr1 returns PRESET; addr2 returns COUNT; addr3 returns 0.
  - rdata is combinational from the current registers, independent of sel.
- Writes:
  - Effective at clk edge when sel&we.
  - CTRL keeps wdata[3:0] and drops the upper bits.
  - Writes to COUNT and to the reserved address are ignored.
  - Any CTRL write also clears irq_flag.
- FSM: evaluates the registered CTRL/PRESET values from before the edge. A same-cycle write lands at that edge and affects the FSM from the next cycle.
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT<=PRESET, go to CNT.
  - CNT:
    - If !EN, go to IDLE and hold COUNT.
    - Else if COUNT>1, COUNT<=COUNT-1.
    - Else COUNT<=0, irq_flag<=1, go to INT.
  - INT:
    - MODE=00: EN<=0, irq_flag held, go to IDLE.
    - MODE=01: irq_flag<=0, go to IDLE. EN stays 1, so the sequence continues IDLE→LOAD→CNT.
- Timing:
  - With preset P≥1, a CTRL write of EN=1 at edge t gives LOAD in cycle t+1, CNT entered at t+2 with COUNT=P, and INT at t+2+P.
  - Preset 0 behaves like preset 1 (reaches INT after one CNT cycle).
  - Auto-reload period is P+3 cycles.
- irq = irq_flag & CTRL.IM.
  - One-shot: level until a CTRL write or reset.
  - Auto-reload: a single-cycle pulse during INT.
- Simultaneous events:
  - A CPU CTRL write in the INT cycle wins over the FSM's EN clear. The written EN value is kept and irq_flag is cleared.
  - A PRESET write during CNT does not disturb COUNT; the new value takes effect at the next LOAD.
  - Clearing EN during LOAD still loads COUNT; the FSM then goes CNT→IDLE.
- Arithmetic: COUNT never wraps below 0. All values are unsigned 32-bit.
- Reset mid-operation: every register returns to its reset value at the next edge, and irq deasserts that cycle.

Test Plan:
- Reset, then read addr 0/1/2 → rdata = 0, PRESET_RST, 0; irq = 0.
- Write PRESET=5, then CTRL=4'b1001 (EN=1, IM=1, one-shot) → COUNT sequence 5,4,3,2,1,0. irq rises at INT and stays high. CTRL reads 4'b1000 afterwards. Writing CTRL=0 clears irq on the next cycle.
- PRESET=3, CTRL=4'b1011 (auto-reload) → one-cycle irq pulses every 6 cycles, and COUNT reloads to 3 each period, over ≥3 periods.
- Counting with IM=0 → the interrupt flag is set but irq stays 0. Setting IM=1 via a CTRL write clears the flag, so irq stays 0.
- Mid-count (COUNT=10): write PRESET=2 → COUNT continues 9,8,… and the next reload uses 2. Write CTRL EN=0 → COUNT freezes; re-enabling reloads from PRESET.
- Write to COUNT (addr 2, 0xDEAD) and to addr 3 → no register changes. Assert reset during CNT → all registers are 0 or PRESET_RST the next cycle.

Source files
------------

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer on the M-stage data bus: one-shot or auto-reload countdown
// from PRESET with a maskable interrupt request.
module timer_dev #(
  parameter logic [31:0] PRESET_RST = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic ctrl_wr, preset_wr, en, auto_reload;

  assign ctrl_wr     = sel & we & (addr == 2'd0);
  assign preset_wr   = sel & we & (addr == 2'd1);
  assign en          = ctrl_q[0];
  // MODE 1x falls back to one-shot.
  assign auto_reload = (ctrl_q[2:1] == 2'b01);

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ctrl_q     <= 4'd0;
      preset_q   <= PRESET_RST;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (en) state_d = StLoad;
      StLoad: state_d = StCnt;
      StCnt: begin
        if (!en) begin
          state_d = StIdle;
        end else if (count_q <= 32'd1) begin
          state_d = StInt;
        end
      end
      StInt: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output/datapath logic; CPU writes are applied last so they win over FSM updates.
  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    unique case (state_q)
      StIdle: ;
      StLoad: count_d = preset_q;
      StCnt: begin
        if (en) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d    = 32'd0;
            irq_flag_d = 1'b1;
          end
        end
      end
      StInt: begin
        if (auto_reload) begin
          irq_flag_d = 1'b0;
        end else begin
          ctrl_d[0] = 1'b0;
        end
      end
      default: ;
    endcase
    if (ctrl_wr) begin
      ctrl_d     = wdata[3:0];
      irq_flag_d = 1'b0;
    end
    if (preset_wr) begin
      preset_d = wdata;
    end
  end

  always_comb begin
    rdata = 32'd0;
    unique case (addr)
      2'd0:    rdata = {28'd0, ctrl_q};
      2'd1:    rdata = preset_q;
      2'd2:    rdata = count_q;
      default: rdata = 32'd0;
    endcase
  end

  assign irq = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: a per-cycle vector table plus hand-written corner sequences.
module tb_timer_dev;

  localparam logic [31:0] PR = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int failures = 0;

  timer_dev #(.PRESET_RST(PR)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic [31:0] er, input logic ei);
    vec_t v;
    v.sel = s; v.we = w; v.addr = a; v.wdata = d; v.exp_rdata = er; v.exp_irq = ei;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive a bus cycle, let the edge take it, then idle the bus.
  task automatic cyc(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d);
    sel = s; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  initial begin
    // Reset values
    add(1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, PR, 0);
    add(1, 0, 2, 0, 0, 0);
    // One-shot, PRESET=5, IM=1
    add(1, 1, 1, 5, PR, 0);
    add(1, 1, 0, 9, 0, 0);
    add(1, 0, 2, 0, 0, 0);   // IDLE
    add(1, 0, 2, 0, 0, 0);   // LOAD
    add(1, 0, 2, 0, 5, 0);
    add(1, 0, 2, 0, 4, 0);
    add(1, 0, 2, 0, 3, 0);
    add(1, 0, 2, 0, 2, 0);
    add(1, 0, 2, 0, 1, 0);
    add(1, 0, 2, 0, 0, 1);   // INT
    add(1, 0, 0, 0, 8, 1);
    add(1, 0, 0, 0, 8, 1);
    add(1, 1, 0, 0, 8, 1);
    add(1, 0, 0, 0, 0, 0);
    // Auto-reload, PRESET=3, period 6
    add(1, 1, 1, 3, 5, 0);
    add(1, 1, 0, 32'hB, 0, 0);
    add(1, 0, 2, 0, 0, 0);
    add(1, 0, 2, 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      add(1, 0, 2, 0, 3, 0);
      add(1, 0, 2, 0, 2, 0);
      add(1, 0, 2, 0, 1, 0);
      add(1, 0, 2, 0, 0, 1);
      if (p < 2) begin
        add(1, 0, 2, 0, 0, 0);
        add(1, 0, 2, 0, 0, 0);
      end
    end
    add(1, 0, 0, 0, 32'hB, 0);
    // EN cleared during LOAD: COUNT still loads, then CNT->IDLE holds it
    add(1, 1, 0, 0, 32'hB, 0);
    add(1, 0, 2, 0, 3, 0);
    add(1, 0, 2, 0, 3, 0);
    // IM=0: flag set but irq stays low; enabling IM by CTRL write clears flag
    add(1, 1, 1, 1, 3, 0);
    add(1, 1, 0, 1, 0, 0);
    add(1, 0, 2, 0, 3, 0);
    add(1, 0, 2, 0, 3, 0);
    add(1, 0, 2, 0, 1, 0);
    add(1, 0, 2, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 8, 0, 0);
    add(1, 0, 0, 0, 8, 0);
    // CTRL drops upper bits; COUNT and reserved writes ignored; sel=0 ignored
    add(1, 1, 0, 32'hFFFF_FFF0, 8, 0);
    add(1, 0, 0, 0, 0, 0);
    add(1, 1, 2, 32'hDEAD, 0, 0);
    add(1, 1, 3, 32'hBEEF, 0, 0);
    add(1, 0, 2, 0, 0, 0);
    add(1, 0, 3, 0, 0, 0);
    add(1, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 32'h77, 1, 0);
    add(1, 0, 1, 0, 1, 0);

    sel = 0; we = 0; addr = 0; wdata = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (vecs[i]) begin
      sel = vecs[i].sel; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
      @(posedge clk);
      #1;
    end
    sel = 0; we = 0;

    // Mid-count PRESET change, EN freeze and re-enable
    cyc(1, 1, 1, 12);
    cyc(1, 1, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rd(2, 12, "mid count12");
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rd(2, 10, "mid count10");
    cyc(1, 1, 1, 2);
    rd(2, 9, "mid preset_wr keeps count");
    rd(1, 2, "mid preset value");
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    rd(2, 7, "mid last decrement");
    cyc(0, 0, 0, 0);
    rd(2, 7, "mid frozen a");
    cyc(0, 0, 0, 0);
    rd(2, 7, "mid frozen b");
    cyc(1, 1, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rd(2, 2, "mid reload new preset");
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rd(2, 0, "int count");
    // CTRL write in INT wins over the one-shot EN clear
    cyc(1, 1, 0, 9);
    rd(0, 9, "int ctrl write wins");
    chk("int ctrl write irq", {31'd0, irq}, 32'd0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rd(2, 2, "int restart count");
    cyc(0, 0, 0, 0);
    rd(2, 1, "pre-reset count");
    // Reset while counting
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd(0, 0, "rst ctrl");
    rd(1, PR, "rst preset");
    rd(2, 0, "rst count");
    chk("rst irq", {31'd0, irq}, 32'd0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rd(2, 0, "rst stays idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
